// File: rtl/nios_system_button_poller.sv
// Avalon-MM poller for the pushbutton PIO: samples on a fixed tick,
// debounces each button and streams press/release events.
module nios_system_button_poller #(
  parameter int WIDTH      = 4,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_press,
  output logic [WIDTH-1:0] evt_release,
  output logic             evt_overflow,
  input  logic             overflow_clr
);

  localparam int TW = $clog2(POLL_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT,
    UPDATE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [WIDTH-1:0]       sample;
  logic [WIDTH-1:0][CW-1:0] dbc;
  logic [WIDTH-1:0][CW-1:0] dbc_nxt;
  logic [WIDTH-1:0]       btn_nxt;
  logic [WIDTH-1:0]       press;
  logic [WIDTH-1:0]       release_bits;
  logic                   upd;
  logic                   has_evt;
  logic                   xfer;
  logic                   unused_rd;

  assign unused_rd   = ^avm_readdata[31:WIDTH];
  assign tick        = (tick_cnt == TW'(POLL_DIV - 1));
  assign avm_address = 2'b00;
  assign avm_read    = (state == REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick) state_nxt = REQ;
      REQ:     state_nxt = LAT;
      LAT:     state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave data is valid during LAT, one cycle after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample <= '0;
    end else if (state == LAT) begin
      sample <= ACTIVE_LOW ? ~avm_readdata[WIDTH-1:0]
                           :  avm_readdata[WIDTH-1:0];
    end
  end

  always_comb begin
    btn_nxt = btn_state;
    dbc_nxt = dbc;
    for (int i = 0; i < WIDTH; i++) begin
      if (sample[i] == btn_state[i]) begin
        dbc_nxt[i] = '0;
      end else if (dbc[i] == CW'(DEBOUNCE - 1)) begin
        btn_nxt[i] = ~btn_state[i];
        dbc_nxt[i] = '0;
      end else begin
        dbc_nxt[i] = dbc[i] + 1'b1;
      end
    end
  end

  assign press        = ~btn_state & btn_nxt;
  assign release_bits = btn_state & ~btn_nxt;
  assign upd          = (state == UPDATE);
  assign has_evt      = upd && |(press | release_bits);
  assign xfer         = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_state <= '0;
      dbc       <= '0;
    end else if (upd) begin
      btn_state <= btn_nxt;
      dbc       <= dbc_nxt;
    end
  end

  // A new event either replaces an accepted one or merges into it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_press   <= '0;
      evt_release <= '0;
    end else if (has_evt) begin
      evt_valid <= 1'b1;
      if (!evt_valid || evt_ready) begin
        evt_press   <= press;
        evt_release <= release_bits;
      end else begin
        evt_press   <= evt_press | press;
        evt_release <= evt_release | release_bits;
      end
    end else if (xfer) begin
      evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_overflow <= 1'b0;
    end else if (has_evt && evt_valid && !evt_ready) begin
      evt_overflow <= 1'b1;
    end else if (overflow_clr) begin
      evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_system_button_poller.sv
// Directed bench for the button poller
// (POLL_DIV=8, DEBOUNCE=3, active-low, 4 buttons).
module tb_nios_system_button_poller;

  logic        clk;
  logic        reset_n;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [3:0]  btn_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_press;
  logic [3:0]  evt_release;
  logic        evt_overflow;
  logic        overflow_clr;

  int checks;
  int failures;

  nios_system_button_poller #(
    .WIDTH(4),
    .POLL_DIV(8),
    .DEBOUNCE(3),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_press(evt_press),
    .evt_release(evt_release),
    .evt_overflow(evt_overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_btn"}, 32'(btn_state), 0);
    check({tag, "_valid"}, 32'(evt_valid), 0);
    check({tag, "_press"}, 32'(evt_press), 0);
    check({tag, "_rel"}, 32'(evt_release), 0);
    check({tag, "_ovf"}, 32'(evt_overflow), 0);
    check({tag, "_read"}, 32'(avm_read), 0);
    check({tag, "_addr"}, 32'(avm_address), 0);
  endtask

  // Waits for the next strobe, then returns on the negedge where the
  // update is visible. clr drives overflow_clr during UPDATE.
  task automatic wait_poll(input bit clr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (avm_read) seen = 1'b1;
    end
    if (!seen) begin
      check("poll_timeout", 0, 1);
    end else begin
      @(negedge clk);
      @(negedge clk);
      overflow_clr = clr;
      @(negedge clk);
      overflow_clr = 1'b0;
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    avm_readdata = 32'h0;
    evt_ready    = 1'b1;
    overflow_clr = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check_zero("rst");
    avm_readdata = 32'hE;
    @(negedge clk);
    reset_n = 1'b1;

    // Strobe cadence and clean press of button 0
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      check($sformatf("read_k%0d", k), 32'(avm_read),
            (k % 8 == 0) ? 1 : 0);
      check($sformatf("btn_k%0d", k), 32'(btn_state),
            (k >= 27) ? 1 : 0);
      check($sformatf("valid_k%0d", k), 32'(evt_valid),
            (k == 27) ? 1 : 0);
      if (k == 27) begin
        check("clean_press", 32'(evt_press), 1);
        check("clean_rel", 32'(evt_release), 0);
      end
    end
    check("addr", 32'(avm_address), 0);

    // Bounce on button 1 rejected
    avm_readdata = 32'hC;
    wait_poll(1'b0);
    check("bounce_cnt1", 32'(dut.dbc[1]), 1);
    check("bounce_v1", 32'(evt_valid), 0);
    wait_poll(1'b0);
    check("bounce_cnt2", 32'(dut.dbc[1]), 2);
    check("bounce_v2", 32'(evt_valid), 0);
    avm_readdata = 32'hE;
    wait_poll(1'b0);
    check("bounce_cnt0", 32'(dut.dbc[1]), 0);
    check("bounce_btn", 32'(btn_state), 1);
    check("bounce_v3", 32'(evt_valid), 0);

    // Simultaneous press of 2 and release of 0
    avm_readdata = 32'hB;
    for (int p = 1; p <= 3; p++) begin
      wait_poll(1'b0);
      check($sformatf("sim_valid_p%0d", p), 32'(evt_valid),
            (p == 3) ? 1 : 0);
    end
    check("sim_press", 32'(evt_press), 4);
    check("sim_rel", 32'(evt_release), 1);
    check("sim_btn", 32'(btn_state), 4);
    @(negedge clk);
    check("sim_drop", 32'(evt_valid), 0);

    // Backpressure merge
    evt_ready    = 1'b0;
    avm_readdata = 32'hA;
    repeat (3) wait_poll(1'b0);
    check("bp_valid1", 32'(evt_valid), 1);
    check("bp_press1", 32'(evt_press), 1);
    check("bp_ovf1", 32'(evt_overflow), 0);
    avm_readdata = 32'h8;
    wait_poll(1'b0);
    wait_poll(1'b0);
    check("bp_hold", 32'(evt_press), 1);
    wait_poll(1'b1);
    check("bp_press2", 32'(evt_press), 3);
    check("bp_rel2", 32'(evt_release), 0);
    check("bp_btn2", 32'(btn_state), 7);
    check("bp_ovf_setwins", 32'(evt_overflow), 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("bp_ovf_clr", 32'(evt_overflow), 0);
    check("bp_valid_held", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    check("bp_xfer_valid", 32'(evt_valid), 1);
    @(negedge clk);
    check("bp_xfer_drop", 32'(evt_valid), 0);
    check("bp_payload_held", 32'(evt_press), 3);

    // Reset during LAT of a debounce-completing poll
    avm_readdata = 32'hF;
    wait_poll(1'b0);
    wait_poll(1'b0);
    check("mid_btn_before", 32'(btn_state), 7);
    for (int i = 0; i < 20 && !avm_read; i++) @(negedge clk);
    check("mid_seen_read", 32'(avm_read), 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("mid");
    avm_readdata = 32'hE;
    reset_n = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      wait_poll(1'b0);
      check($sformatf("re_btn_p%0d", p), 32'(btn_state),
            (p == 3) ? 1 : 0);
      check($sformatf("re_valid_p%0d", p), 32'(evt_valid),
            (p == 3) ? 1 : 0);
    end
    check("re_press", 32'(evt_press), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
